bp_me_wormhole_packet_decode_mem_resp: RTL and testbench
========================================================

Name: bp_me_wormhole_packet_decode_mem_resp

Overview:
- Receive side of the memory-response wormhole link.
- Accepts flits from a wormhole router port, deserializes one packet into a header buffer plus a data buffer, and presents the recovered bp_cce_mem_msg header, payload data and source routing fields to the consuming CCE/LCE-side logic.
- Inverse of the mem_resp packet encoder. Single-packet buffer with valid/ready on both sides.

Parameters:
- flit_width_p, 64: wormhole flit width in bits.
- cord_width_p, 5: router coordinate width.
- cid_width_p, 2: concentrator id width.
- len_width_p, 4: length field width. Value = flits in packet minus 1.
- msg_hdr_width_p, 88: bp_cce_mem_msg header width.
- data_width_p, 512: maximum payload width (cce block width).
- Derived (localparam): wh_hdr_width_lp = 2*cord_width_p + 2*cid_width_p + len_width_p + msg_hdr_width_p.
- Derived (localparam): max_flits_lp = CDIV(wh_hdr_width_lp + data_width_p, flit_width_p).

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: asynchronous, active-low reset. Asserted when 0.
- link_data_i, in, flit_width_p: incoming flit.
- link_v_i, in, 1: flit valid.
- link_ready_and_o, out, 1: flit accepted when link_v_i & link_ready_and_o.
- mem_resp_header_o, out, msg_hdr_width_p: recovered message header.
- mem_resp_data_o, out, data_width_p: recovered payload, LSB-aligned.
- src_cord_o, out, cord_width_p: sender coordinate.
- src_cid_o, out, cid_width_p: sender concentrator id.
- mem_resp_v_o, out, 1: packet complete.
- mem_resp_yumi_i, in, 1: consumer takes packet. Legal only while mem_resp_v_o.
- len_err_o, out, 1: sticky flag, received len >= max_flits_lp.

Behaviour:
- Packet bit layout, LSB first: cord, len, cid, src_cord, src_cid, msg_hdr, data. Flit k fills packet bits [k*flit_width_p +: flit_width_p].
- Reset (reset_i==0, async):
  - State goes to e_ready. Flit counter = 0.
  - Packet buffer cleared to 0. len_err_o = 0. mem_resp_v_o = 0.
  - link_ready_and_o = 0 while reset is asserted; it rises the first cycle after deassertion.
- State e_ready:
  - link_ready_and_o = 1.
  - On accept: clear the buffer, then write the flit into slot 0. Capture len from bits [cord_width_p +: len_width_p].
  - If len == 0, go to e_out. Otherwise counter = 1 and go to e_collect.
- State e_collect:
  - link_ready_and_o = 1.
  - Each accepted flit is written to slot counter; counter increments.
  - When the flit accepted has counter == len, go to e_out.
  - Cycles with no link_v_i hold state.
- State e_out:
  - mem_resp_v_o = 1. link_ready_and_o = 0 (no bypass, no overlap).
  - All outputs are driven from registers and are stable until the yumi.
  - On mem_resp_yumi_i, go to e_ready. The next flit can be accepted the cycle after the yumi.
- Latency: mem_resp_v_o is asserted the cycle after the last flit is accepted. Minimum occupancy is len+2 cycles per packet.
- Payload: bits not carried by the packet read as 0. Size-based masking is not done here; the consumer uses header.size.
- len >= max_flits_lp:
  - Set len_err_o (cleared only by reset).
  - Keep accepting flits until counter == len so the link drains. Writes to slots >= max_flits_lp are discarded; the counter saturates at len_width_p range.
  - Then enter e_out as normal.
- mem_resp_yumi_i outside e_out is ignored. Assertion in simulation.
- Reset asserted mid-packet: the partial packet is dropped. The upstream router must also be reset.

Test Plan:
- Ack packet, len=1 (106-bit header, 2 flits), msg_type=e_mem_msg_wr, src_cord=3, src_cid=1:
  - mem_resp_v_o rises 1 cycle after flit 1.
  - header matches the sent header, src fields = 3/1, data = 0.
- Read, size 8B, len=2:
  - 3 flits, payload 0xDEADBEEF_CAFEF00D.
  - data_o[63:0] holds the payload, data_o[511:64] = 0.
- Read, size 64B, len=9:
  - 10 flits sent with link_v_i gaps of 0–3 random cycles.
  - All 512 data bits recovered.
  - link_ready_and_o = 0 throughout e_out.
- Backpressure: hold yumi low 20 cycles with the next packet pending.
  - No flit is accepted and outputs stay stable.
  - After the yumi, the second packet decodes correctly.
- Error case: len field = 12 (>= max_flits_lp = 10).
  - 13 flits accepted, len_err_o = 1 and stays 1.
  - A following valid packet still decodes correctly.
- Async reset asserted after 4 of 10 flits:
  - Outputs are at reset values immediately, without waiting for a clock edge.
  - After release, a fresh 2-flit packet decodes correctly.

Source files
------------

// File: rtl/bp_me_wormhole_packet_decode_mem_resp_if.sv
// Link-side and consumer-side signals of the mem_resp wormhole decoder.
// slave = decoder, master = the surrounding router port plus consumer.
interface bp_me_wormhole_packet_decode_mem_resp_if #(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 5,
  parameter int cid_width_p     = 2,
  parameter int msg_hdr_width_p = 88,
  parameter int data_width_p    = 512
);
  logic [flit_width_p-1:0]    link_data_i;
  logic                       link_v_i;
  logic                       link_ready_and_o;
  logic [msg_hdr_width_p-1:0] mem_resp_header_o;
  logic [data_width_p-1:0]    mem_resp_data_o;
  logic [cord_width_p-1:0]    src_cord_o;
  logic [cid_width_p-1:0]     src_cid_o;
  logic                       mem_resp_v_o;
  logic                       mem_resp_yumi_i;
  logic                       len_err_o;

  modport slave (
    input  link_data_i, link_v_i, mem_resp_yumi_i,
    output link_ready_and_o, mem_resp_header_o, mem_resp_data_o,
           src_cord_o, src_cid_o, mem_resp_v_o, len_err_o
  );

  modport master (
    output link_data_i, link_v_i, mem_resp_yumi_i,
    input  link_ready_and_o, mem_resp_header_o, mem_resp_data_o,
           src_cord_o, src_cid_o, mem_resp_v_o, len_err_o
  );
endinterface

// File: rtl/bp_me_wormhole_packet_decode_mem_resp.sv
// Receive side of the mem_resp wormhole link: collects one packet of flits
// into a slot buffer and presents header, payload and source routing fields.

// One flit-wide buffer slot. A write wins over a clear so slot 0 can be
// cleared and loaded with the head flit in the same cycle.
module bp_me_wormhole_packet_decode_mem_resp_slot #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);
  // slot register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)   q_o <= '0;
    else if (we_i)  q_o <= d_i;
    else if (clr_i) q_o <= '0;
  end
endmodule

module bp_me_wormhole_packet_decode_mem_resp #(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 5,
  parameter int cid_width_p     = 2,
  parameter int len_width_p     = 4,
  parameter int msg_hdr_width_p = 88,
  parameter int data_width_p    = 512
) (
  input  logic clk_i,
  input  logic reset_i,
  bp_me_wormhole_packet_decode_mem_resp_if.slave io
);
  localparam int wh_hdr_width_lp = 2*cord_width_p + 2*cid_width_p + len_width_p + msg_hdr_width_p;
  localparam int max_flits_lp    = (wh_hdr_width_lp + data_width_p + flit_width_p - 1) / flit_width_p;
  localparam int pkt_width_lp    = max_flits_lp * flit_width_p;
  localparam int pad_lp          = pkt_width_lp - wh_hdr_width_lp - data_width_p;

  // Packet header as laid out on the wire, LSB first from cord upward.
  typedef struct packed {
    logic [msg_hdr_width_p-1:0] msg_hdr;
    logic [cid_width_p-1:0]     src_cid;
    logic [cord_width_p-1:0]    src_cord;
    logic [cid_width_p-1:0]     cid;
    logic [len_width_p-1:0]     len;
    logic [cord_width_p-1:0]    cord;
  } wh_hdr_s;

  typedef enum logic [1:0] {e_ready, e_collect, e_out} state_e;

  state_e                                    state_r, state_n;
  logic [len_width_p-1:0]                    cnt_r, cnt_n;
  logic                                      rdy_en_r;
  logic                                      len_err_r;
  logic                                      accept;
  logic                                      slot_clr;
  logic [max_flits_lp-1:0]                   slot_we;
  logic [max_flits_lp-1:0][flit_width_p-1:0] slot_q;
  logic [pkt_width_lp-1:0]                   pkt;
  logic [len_width_p-1:0]                    in_len;
  wh_hdr_s                                   hdr;

  assign pkt    = slot_q;
  assign hdr    = wh_hdr_s'(pkt[wh_hdr_width_lp-1:0]);
  assign in_len = io.link_data_i[cord_width_p +: len_width_p];

  // rdy_en_r keeps the link stalled until the first edge after reset release.
  assign io.link_ready_and_o = rdy_en_r & (state_r != e_out);
  assign accept              = io.link_v_i & io.link_ready_and_o;

  for (genvar k = 0; k < max_flits_lp; k++) begin : g_slot
    bp_me_wormhole_packet_decode_mem_resp_slot #(.width_p(flit_width_p)) u_slot (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (slot_clr),
      .we_i    (slot_we[k]),
      .d_i     (io.link_data_i),
      .q_o     (slot_q[k])
    );
  end

  // state, counter, ready gate and sticky length error
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r   <= e_ready;
      cnt_r     <= '0;
      rdy_en_r  <= 1'b0;
      len_err_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      rdy_en_r <= 1'b1;
      if (accept && state_r == e_ready && 32'(in_len) >= max_flits_lp)
        len_err_r <= 1'b1;
    end
  end

  // next state and slot write enables; slots past the buffer are never
  // selected, so over-long packets drain without corrupting the payload
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    slot_clr = 1'b0;
    slot_we  = '0;
    case (state_r)
      e_ready: if (accept) begin
        slot_clr   = 1'b1;
        slot_we[0] = 1'b1;
        if (in_len == '0) begin
          state_n = e_out;
        end else begin
          cnt_n   = len_width_p'(1);
          state_n = e_collect;
        end
      end
      e_collect: if (accept) begin
        for (int k = 0; k < max_flits_lp; k++)
          if (32'(cnt_r) == k) slot_we[k] = 1'b1;
        if (cnt_r == hdr.len) begin
          cnt_n   = '0;
          state_n = e_out;
        end else if (cnt_r != '1) begin
          cnt_n = cnt_r + 1'b1;
        end
      end
      e_out: if (io.mem_resp_yumi_i) state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  assign io.mem_resp_v_o      = (state_r == e_out);
  assign io.mem_resp_header_o = hdr.msg_hdr;
  assign io.src_cord_o        = hdr.src_cord;
  assign io.src_cid_o         = hdr.src_cid;
  assign io.mem_resp_data_o   = pkt[wh_hdr_width_lp +: data_width_p];
  assign io.len_err_o         = len_err_r;

  // destination routing fields are consumed by the router, not here
  logic unused_hdr;
  assign unused_hdr = ^{hdr.cord, hdr.cid};

  if (pad_lp > 0) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^pkt[pkt_width_lp-1 -: pad_lp];
  end

  // the consumer may only take a packet that is being offered
  a_yumi_in_out: assert property (@(posedge clk_i) disable iff (!reset_i)
    io.mem_resp_yumi_i |-> state_r == e_out);
endmodule

// File: tb/tb_bp_me_wormhole_packet_decode_mem_resp.sv
// Directed bench for the mem_resp wormhole decoder: a vector table of
// packets plus hand-written backpressure, length-error and reset sequences.
module tb_bp_me_wormhole_packet_decode_mem_resp;
  logic clk = 1'b0;
  logic reset_i;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_me_wormhole_packet_decode_mem_resp_if bus ();

  bp_me_wormhole_packet_decode_mem_resp dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (bus)
  );

  typedef struct {
    logic [4:0]   cord;
    logic [3:0]   len;
    logic [1:0]   cid;
    logic [4:0]   scord;
    logic [1:0]   scid;
    logic [87:0]  hdr;
    logic [511:0] data;
    int           gap;
    logic [87:0]  exp_hdr;
    logic [511:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // wire image of a packet: cord, len, cid, src_cord, src_cid, hdr, data
  function automatic logic [1023:0] build(input vec_t v);
    logic [1023:0] p;
    p = '0;
    p[4:0]     = v.cord;
    p[8:5]     = v.len;
    p[10:9]    = v.cid;
    p[15:11]   = v.scord;
    p[17:16]   = v.scid;
    p[105:18]  = v.hdr;
    p[617:106] = v.data;
    if (v.len >= 4'd10) p[1023:640] = '1;
    return p;
  endfunction

  task automatic send_flit(input logic [63:0] d, input int gapmax);
    bit acc;
    int n;
    repeat ($urandom_range(0, gapmax)) begin
      bus.link_v_i = 1'b0;
      @(posedge clk); #1;
    end
    bus.link_v_i    = 1'b1;
    bus.link_data_i = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = bus.link_ready_and_o;
      @(posedge clk); #1;
      n++;
    end
    bus.link_v_i = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept within 50 cycles");
    end
  endtask

  task automatic send_all(input vec_t v);
    logic [1023:0] p;
    p = build(v);
    for (int k = 0; k < int'(v.len); k++) send_flit(p[k*64 +: 64], v.gap);
    chk("v_before_last", 512'(bus.mem_resp_v_o), 512'(0));
    send_flit(p[int'(v.len)*64 +: 64], v.gap);
    chk("v_after_last", 512'(bus.mem_resp_v_o), 512'(1));
  endtask

  task automatic check_out(input vec_t v);
    chk("header",   512'(bus.mem_resp_header_o), 512'(v.exp_hdr));
    chk("data",     bus.mem_resp_data_o, v.exp_data);
    chk("src_cord", 512'(bus.src_cord_o), 512'(v.scord));
    chk("src_cid",  512'(bus.src_cid_o), 512'(v.scid));
    chk("len_err",  512'(bus.len_err_o), 512'(v.exp_err));
    chk("ready_out", 512'(bus.link_ready_and_o), 512'(0));
  endtask

  task automatic pop();
    bus.mem_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.mem_resp_yumi_i = 1'b0;
    chk("v_after_yumi",     512'(bus.mem_resp_v_o), 512'(0));
    chk("ready_after_yumi", 512'(bus.link_ready_and_o), 512'(1));
  endtask

  task automatic run_pkt(input vec_t v);
    send_all(v);
    check_out(v);
    repeat (2) begin
      @(posedge clk); #1;
      chk("ready_hold", 512'(bus.link_ready_and_o), 512'(0));
      chk("v_hold",     512'(bus.mem_resp_v_o), 512'(1));
    end
    pop();
  endtask

  initial begin
    logic [511:0] pat_a, pat_b, ones;
    logic [1023:0] p;
    vec_t va, vb;

    // non-periodic payloads so a misplaced flit shows up in the data
    for (int j = 0; j < 16; j++) begin
      pat_a[j*32 +: 32] = 32'h9E3779B9 * (j + 1);
      pat_b[j*32 +: 32] = 32'h7F4A7C15 ^ (32'h01010101 * (j + 3));
    end
    ones = '1;

    // ack: len=1, header fits two flits, no payload
    tbl[0] = '{5'h07, 4'd1, 2'd2, 5'd3, 2'd1, 88'h12_3456_789A_BCDE_F000_0001,
               512'h0, 0, 88'h12_3456_789A_BCDE_F000_0001, 512'h0, 1'b0};
    // 8B read
    tbl[1] = '{5'h01, 4'd2, 2'd0, 5'h1A, 2'd2, 88'hA5_0000_0000_0000_0000_3008,
               512'hDEADBEEF_CAFEF00D, 1, 88'hA5_0000_0000_0000_0000_3008,
               512'hDEADBEEF_CAFEF00D, 1'b0};
    // 64B read, gaps of 0..3 cycles between flits
    tbl[2] = '{5'h1F, 4'd9, 2'd3, 5'h11, 2'd3, 88'hFEDC_BA98_7654_3210_0F0F_0F,
               pat_a, 3, 88'hFEDC_BA98_7654_3210_0F0F_0F, pat_a, 1'b0};
    // len=1 carries only data[21:0]; rest must read 0 after the 64B packet
    tbl[3] = '{5'h02, 4'd1, 2'd1, 5'd0, 2'd0, 88'h0,
               ones, 0, 88'h0, 512'h3FFFFF, 1'b0};
    // len=0: a single flit carries header bits [45:0] only
    tbl[4] = '{5'h04, 4'd0, 2'd1, 5'h15, 2'd2, 88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               ones, 2, 88'h3FFF_FFFF_FFFF, 512'h0, 1'b0};
    // len=12 >= 10 flits: drains 13 flits, extra flits dropped
    tbl[5] = '{5'h03, 4'd12, 2'd2, 5'h0C, 2'd1, 88'h55_AAAA_5555_AAAA_5555_AAAA,
               pat_b, 1, 88'h55_AAAA_5555_AAAA_5555_AAAA, pat_b, 1'b1};
    // good packet after the error; flag stays set
    tbl[6] = '{5'h08, 4'd2, 2'd3, 5'h1E, 2'd0, 88'h00_1111_2222_3333_4444_5555,
               512'h0123_4567_89AB_CDEF, 0, 88'h00_1111_2222_3333_4444_5555,
               512'h0123_4567_89AB_CDEF, 1'b1};

    bus.link_v_i        = 1'b0;
    bus.link_data_i     = '0;
    bus.mem_resp_yumi_i = 1'b0;
    reset_i             = 1'b0;

    // reset state
    #12;
    chk("rst_ready",   512'(bus.link_ready_and_o), 512'(0));
    chk("rst_v",       512'(bus.mem_resp_v_o), 512'(0));
    chk("rst_len_err", 512'(bus.len_err_o), 512'(0));
    chk("rst_data",    bus.mem_resp_data_o, 512'(0));
    @(posedge clk); #1;
    reset_i = 1'b1;
    chk("ready_at_release", 512'(bus.link_ready_and_o), 512'(0));
    @(posedge clk); #1;
    chk("ready_after_release", 512'(bus.link_ready_and_o), 512'(1));

    for (int i = 0; i < 7; i++) begin
      run_pkt(tbl[i]);
      chk("len_err_sticky", 512'(bus.len_err_o), 512'(tbl[i].exp_err));
    end

    // backpressure: next head flit waits while the consumer stalls
    va = tbl[6];
    vb = tbl[2];
    vb.exp_err = 1'b1;
    send_all(va);
    check_out(va);
    p = build(vb);
    bus.link_v_i    = 1'b1;
    bus.link_data_i = p[63:0];
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_ready", 512'(bus.link_ready_and_o), 512'(0));
      chk("bp_v",     512'(bus.mem_resp_v_o), 512'(1));
      chk("bp_data",  bus.mem_resp_data_o, va.exp_data);
      chk("bp_hdr",   512'(bus.mem_resp_header_o), 512'(va.exp_hdr));
    end
    pop();
    run_pkt(vb);

    // async reset mid-packet: 4 of 10 flits in, reset between edges
    p = build(tbl[2]);
    for (int k = 0; k < 4; k++) send_flit(p[k*64 +: 64], 0);
    #2;
    reset_i = 1'b0;
    #1;
    chk("mid_rst_ready",   512'(bus.link_ready_and_o), 512'(0));
    chk("mid_rst_v",       512'(bus.mem_resp_v_o), 512'(0));
    chk("mid_rst_len_err", 512'(bus.len_err_o), 512'(0));
    chk("mid_rst_data",    bus.mem_resp_data_o, 512'(0));
    chk("mid_rst_hdr",     512'(bus.mem_resp_header_o), 512'(0));
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_up", 512'(bus.link_ready_and_o), 512'(1));
    run_pkt(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
